datamem_responder: RTL and testbench
====================================

# datamem_responder

Multi-cycle data-memory responder: the memory-side end of the CPU's load/store interface. It accepts one word-aligned read or write request through a valid/ready handshake, holds it for a fixed number of wait states, then returns a response through a second valid/ready handshake. It replaces the zero-latency data port when the team moves to the multicycle CPU, and lets the bench model slow memory.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-address bits; the array holds 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 2: cycles from request acceptance to `resp_valid`. Legal range 1..15.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  1: initiator presents a request.
- `req_ready`  out  1: responder can accept a request.
- `req_we`  in  1: 1 = store word, 0 = load word.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data.
- `resp_valid`  out  1: response available.
- `resp_ready`  in  1: initiator takes the response.
- `resp_rdata`  out  32: load data; 0 for stores and errors.
- `resp_err`  out  1: the request was misaligned or out of range.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `req_we`, `req_addr` and `req_wdata`, load the wait counter with `LATENCY`-1, and go to WAIT.
- WAIT:
  - `req_ready`=0.
  - The counter decrements each cycle.
  - At count 0, perform the access:
    - A read samples the array into `resp_rdata`.
    - A write commits `req_wdata` to the array and sets `resp_rdata`=0.
  - Then set `resp_valid` and go to RESP.
- RESP:
  - `resp_valid`=1, and `resp_rdata` and `resp_err` stay stable.
  - On `resp_ready`=1, clear `resp_valid` and return to IDLE.
- Error check, evaluated on the latched address:
  - An address is misaligned if `addr[1:0]` is not 0.
  - An address is out of range if `addr[31:ADDR_WIDTH+2]` is not 0.
  - On either error: no array write, `resp_rdata`=0, `resp_err`=1. The error response still takes the full `LATENCY` and uses the normal handshake.
- Word index is `addr[ADDR_WIDTH+1:2]`.
- Array contents are not cleared by `reset`.
- Only one request is outstanding at a time, so requests never overlap.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter=0.
- A request is accepted at edge N, where `req_valid` and `req_ready` are both 1.
  - `resp_valid` is 1 from edge N+`LATENCY` onward.
  - A write is visible in the array after edge N+`LATENCY`.
- The response completes at edge M, where `resp_valid` and `resp_ready` are both 1.
  - `req_ready`=1 from edge M onward.
  - The earliest next acceptance is edge M+1.
  - Minimum throughput is therefore one request per `LATENCY`+2 cycles.
- If `resp_ready` is already 1 when `resp_valid` rises, the response lasts exactly one cycle.
- Request inputs are sampled only at acceptance, so later changes to them are ignored.
- `reset` asserted in WAIT or RESP:
  - Abort: return to reset values.
  - A write whose commit edge has not yet occurred is discarded.
  - A write that has already committed remains in the array.
- `reset` takes priority over every other event at the same edge.

## Structure
- Shared header `memconst.v` holds:
  - the state encodings IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - the data width of 32;
  - the `LATENCY` legal-range limits.
- The CPU's future multicycle control FSM reuses this header.
- One sub-module: `waitcounter`, a 4-bit loadable down-counter.
  - Ports: `clk`, `reset`, `load`, `value`, `zero`.
- The array is inferred in the top module as a register-file-style memory.

## Test plan
- Write then read (`LATENCY`=2):
  - Store 0xDEADBEEF at 0x10, accepted at edge 0 → `resp_valid` at edge 2 with `resp_err`=0 and `resp_rdata`=0.
  - Load 0x10 → `resp_rdata`=0xDEADBEEF at N+2.
- Backpressure: hold `resp_ready`=0 for 5 cycles → `resp_valid` and the data stay stable, `req_ready` stays 0, and a new `req_valid` is ignored.
- Errors:
  - Store to 0x13 → `resp_err`=1, and a following load of 0x10 returns its prior value.
  - Load from 0x1000 with `ADDR_WIDTH`=10 → `resp_err`=1 and `resp_rdata`=0.
- `LATENCY`=1 and `LATENCY`=15 with `resp_ready` tied to 1 → `resp_valid` pulses for one cycle, exactly `LATENCY` edges after acceptance.
- Reset mid-operation:
  - Store 0x12345678 to 0x20, with 0 previously written there, and assert `reset` one cycle after acceptance (`LATENCY`=3) → outputs return to reset values, and a load of 0x20 returns 0.
- Back-to-back: 8 loads with `resp_ready` held at 1 → each is accepted `LATENCY`+2 cycles after the previous one, and the data matches the preloaded words.

Source files
------------

// File: rtl/datamem_responder_pkg.sv
// Shared constants for the data-memory responder and the multicycle control FSM.
// Holds the state encodings, the data width and the legal wait-state range.
package datamem_responder_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int CNT_WIDTH   = 4;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Misaligned (low two bits set) or beyond the 2^aw word array.
  function automatic logic addr_error(input logic [31:0] addr, input int unsigned aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/datamem_responder_waitcounter.sv
// Loadable 4-bit down-counter that saturates at zero.
// Counts down whenever it is not being loaded; zero flags the end of the wait.
module waitcounter
  import datamem_responder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] value,
  output logic       zero
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/datamem_responder.sv
// Multi-cycle word memory behind a request/response valid-ready pair.
// One request at a time; the access happens LATENCY edges after acceptance.
module datamem_responder
  import datamem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both 1; the request side only transfers in IDLE, the response side
  // only in RESP, and response outputs are held while waiting for resp_ready.

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [31:0]             addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic                    access;
  logic                    cnt_load;
  logic                    cnt_zero;
  logic                    mem_we;
  logic                    req_err;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [DATA_WIDTH-1:0]   mem_rd;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  waitcounter u_waitcounter (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .value (WAIT_INIT),
    .zero  (cnt_zero)
  );

  assign req_err  = addr_error(addr_q, ADDR_WIDTH);
  assign word_idx = addr_q[ADDR_WIDTH+1:2];
  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign access   = (state_q == ST_WAIT) && cnt_zero;
  assign mem_rd   = mem[word_idx];

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately outside reset; reset only blocks a same-edge commit.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[word_idx] <= wdata_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_valid)  state_d = ST_WAIT;
      ST_WAIT: if (cnt_zero)   state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Output and control decode.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    cnt_load  = accept;
    mem_we    = access && we_q && !req_err && !reset;
  end

  // Request capture at acceptance, response capture at the access edge.
  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (accept) begin
      we_d    = req_we;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end
    if (access) begin
      valid_d = 1'b1;
      err_d   = req_err;
      rdata_d = (we_q || req_err) ? '0 : mem_rd;
    end
    if ((state_q == ST_RESP) && resp_ready) begin
      valid_d = 1'b0;
    end
  end

  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_datamem_responder.sv
// Bench for datamem_responder: four instances at LATENCY 2, 1, 15 and 3,
// directed requests feeding an expected-response queue checked by a monitor.
module tb_datamem_responder;

  localparam int NI = 4;
  localparam int EW = 67;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 15 : 3;
  endfunction

  logic        clk;
  logic        reset;
  logic        req_valid_a  [NI];
  logic        req_ready_a  [NI];
  logic        req_we_a     [NI];
  logic [31:0] req_addr_a   [NI];
  logic [31:0] req_wdata_a  [NI];
  logic        resp_valid_a [NI];
  logic        resp_ready_a [NI];
  logic [31:0] resp_rdata_a [NI];
  logic        resp_err_a   [NI];
  logic [1:0]  dbg_state_a  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    datamem_responder #(.ADDR_WIDTH(10), .LATENCY(lat_of(g))) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid_a[g]),
      .req_ready  (req_ready_a[g]),
      .req_we     (req_we_a[g]),
      .req_addr   (req_addr_a[g]),
      .req_wdata  (req_wdata_a[g]),
      .resp_valid (resp_valid_a[g]),
      .resp_ready (resp_ready_a[g]),
      .resp_rdata (resp_rdata_a[g]),
      .resp_err   (resp_err_a[g]),
      .dbg_state  (dbg_state_a[g])
    );
  end

  // Clock, reset and cycle counter.
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Scoreboard state: {inst[1:0], err, rdata[31:0], first_valid_cycle[31:0]}.
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  int            checks = 0;
  int            errors = 0;
  bit            in_resp    [NI];
  logic [31:0]   held_rdata [NI];
  logic          held_err   [NI];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares each new response against the queue head, then holds.
  always @(negedge clk) begin
    if (reset) begin
      for (int g = 0; g < NI; g++) in_resp[g] = 1'b0;
    end else begin
      for (int g = 0; g < NI; g++) begin
        if (resp_valid_a[g]) begin
          if (!in_resp[g]) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL resp_unexpected inst=%0d rdata=%h err=%b expected no response (cycle %0d)",
                       g, resp_rdata_a[g], resp_err_a[g], cyc);
            end else begin
              exp_e = exp_q[0];
              check("resp_inst", 32'(g), 32'(exp_e[66:65]));
              check("resp_err", 32'(resp_err_a[g]), 32'(exp_e[64]));
              check("resp_rdata", resp_rdata_a[g], exp_e[63:32]);
              check("resp_cycle", 32'(cyc), exp_e[31:0]);
            end
            in_resp[g]    = 1'b1;
            held_rdata[g] = resp_rdata_a[g];
            held_err[g]   = resp_err_a[g];
          end else begin
            check("hold_rdata", resp_rdata_a[g], held_rdata[g]);
            check("hold_err", 32'(resp_err_a[g]), 32'(held_err[g]));
          end
          if (resp_ready_a[g]) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            in_resp[g] = 1'b0;
          end
        end else if (in_resp[g]) begin
          checks++;
          errors++;
          $display("FAIL resp_dropped inst=%0d resp_valid=0 expected 1 (cycle %0d)", g, cyc);
          in_resp[g] = 1'b0;
        end
      end
    end
  end

  // Driver: call at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic do_req(input int i, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit exp_err,
                        input logic [31:0] exp_rdata, input bit push, output int acc);
    bit rdy;
    acc = -1;
    req_we_a[i]    = we;
    req_addr_a[i]  = addr;
    req_wdata_a[i] = wdata;
    req_valid_a[i] = 1'b1;
    for (int k = 0; k < 200; k++) begin
      rdy = req_ready_a[i];
      @(posedge clk);
      #1;
      if (rdy) begin
        acc = cyc;
        break;
      end
    end
    req_valid_a[i] = 1'b0;
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout inst=%0d addr=%h req_ready=0 expected 1", i, addr);
    end else if (push) begin
      exp_q.push_back({2'(i), exp_err, exp_rdata, 32'(acc + lat_of(i))});
    end
  endtask

  task automatic wait_done(input int i);
    bit ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0 && !in_resp[i] && req_ready_a[i]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout inst=%0d pending=%0d expected 0", i, exp_q.size());
    end
  endtask

  task automatic txn(input int i, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit exp_err, input logic [31:0] exp_rdata);
    int acc;
    do_req(i, we, addr, wdata, exp_err, exp_rdata, 1'b1, acc);
    wait_done(i);
  endtask

  task automatic check_reset_vals(input int i, input string tag);
    check({tag, "_req_ready"}, 32'(req_ready_a[i]), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid_a[i]), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata_a[i], 32'd0);
    check({tag, "_resp_err"}, 32'(resp_err_a[i]), 32'd0);
    check({tag, "_state"}, 32'(dbg_state_a[i]), 32'd0);
  endtask

  logic [31:0] b2b_data [8];

  initial begin
    int acc;
    int prev;
    bit seen;

    b2b_data = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1234_5678,
                 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'hCAFE_BABE, 32'h0000_0000};
    reset = 1'b1;
    for (int g = 0; g < NI; g++) begin
      req_valid_a[g]  = 1'b0;
      req_we_a[g]     = 1'b0;
      req_addr_a[g]   = '0;
      req_wdata_a[g]  = '0;
      resp_ready_a[g] = 1'b1;
      in_resp[g]      = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int g = 0; g < NI; g++) check_reset_vals(g, "reset");

    // Write then read at LATENCY 2.
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);

    // Backpressure: response held 5 cycles, a new write to 0x10 is ignored.
    resp_ready_a[0] = 1'b0;
    do_req(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, acc);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (resp_valid_a[0]) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("bp_resp_valid_seen", 32'(seen), 32'd1);
    req_we_a[0]    = 1'b1;
    req_addr_a[0]  = 32'h10;
    req_wdata_a[0] = 32'h1111_1111;
    req_valid_a[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_req_ready", 32'(req_ready_a[0]), 32'd0);
      check("bp_resp_valid", 32'(resp_valid_a[0]), 32'd1);
      @(posedge clk);
      #1;
    end
    req_valid_a[0]  = 1'b0;
    resp_ready_a[0] = 1'b1;
    wait_done(0);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);

    // Error responses: misaligned store, out-of-range load and store.
    txn(0, 1'b1, 32'h13, 32'hCAFE_F00D, 1'b1, 32'h0);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);
    txn(0, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0);
    txn(0, 1'b1, 32'h1010, 32'h7777_7777, 1'b1, 32'h0);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);
    txn(0, 1'b1, 32'hFFC, 32'h5A5A_5A5A, 1'b0, 32'h0);
    txn(0, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'h5A5A_5A5A);
    txn(0, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0);

    // LATENCY 1 and 15 with resp_ready tied high.
    txn(1, 1'b1, 32'h0, 32'hA1B2_C3D4, 1'b0, 32'h0);
    txn(1, 1'b0, 32'h0, 32'h0, 1'b0, 32'hA1B2_C3D4);
    txn(2, 1'b1, 32'h4, 32'h0BAD_F00D, 1'b0, 32'h0);
    txn(2, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0BAD_F00D);

    // Reset one cycle after accepting a store (LATENCY 3) discards it.
    txn(3, 1'b1, 32'h20, 32'h0, 1'b0, 32'h0);
    do_req(3, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 32'h0, 1'b0, acc);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_vals(3, "midreset");
    txn(3, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0);

    // Back-to-back loads: one acceptance every LATENCY+2 cycles.
    for (int k = 0; k < 8; k++) txn(0, 1'b1, 32'h100 + 32'(4 * k), b2b_data[k], 1'b0, 32'h0);
    prev = -1;
    for (int k = 0; k < 8; k++) begin
      do_req(0, 1'b0, 32'h100 + 32'(4 * k), 32'h0, 1'b0, b2b_data[k], 1'b1, acc);
      if (prev >= 0) check("b2b_spacing", 32'(acc - prev), 32'd4);
      prev = acc;
    end
    wait_done(0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
